// File: rtl/seg7_pkg.sv
// Purpose: shared constants for the seven-segment scan decoder (segment patterns, special BCD codes, FSM states).
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Segment vectors are ordered ABCDEFG with A in bit 6 and G in bit 0.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;

    // Alternate glyphs some drivers emit (6 without top bar, 7 with F bar, 9 without bottom bar).
    localparam logic [6:0] SEG_6_ALT = 7'b0011111;
    localparam logic [6:0] SEG_7_ALT = 7'b1110010;
    localparam logic [6:0] SEG_9_ALT = 7'b1110011;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] BCD_ERR   = 4'hE;

    typedef enum logic {
        COLLECT = 1'b0,
        OFFER   = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Purpose: map one 7-bit segment pattern back to a BCD code plus an illegal-pattern flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none.
//
// Ports: seg[6:0] pattern in (A..G), code[3:0] decoded digit / BCD_BLANK / BCD_ERR, err high for illegal patterns.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code,
    output logic       err
);

    always_comb begin
        code = BCD_ERR;
        err  = 1'b1;
        case (seg)
            SEG_0:              begin code = 4'd0;      err = 1'b0; end
            SEG_1:              begin code = 4'd1;      err = 1'b0; end
            SEG_2:              begin code = 4'd2;      err = 1'b0; end
            SEG_3:              begin code = 4'd3;      err = 1'b0; end
            SEG_4:              begin code = 4'd4;      err = 1'b0; end
            SEG_5:              begin code = 4'd5;      err = 1'b0; end
            SEG_6, SEG_6_ALT:   begin code = 4'd6;      err = 1'b0; end
            SEG_7, SEG_7_ALT:   begin code = 4'd7;      err = 1'b0; end
            SEG_8:              begin code = 4'd8;      err = 1'b0; end
            SEG_9, SEG_9_ALT:   begin code = 4'd9;      err = 1'b0; end
            SEG_BLANK:          begin code = BCD_BLANK; err = 1'b0; end
            default:            begin code = BCD_ERR;   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Purpose: debounce a multiplexed seven-segment scan bus per digit and deliver decoded multi-digit BCD frames.
// Latency: a digit commits on its STABLE_CNT-th matching strobe; a frame is offered on the edge completing the set.
// Backpressure: out_valid/out_ready; an offered frame is held while sampling continues into a shadow for the next one.
//
// Ports: clk, rst_n (async, active-low); seg[6:0] shared segments; digit_sel one-hot strobes;
//        out_valid/out_ready frame handshake; frame_bcd (digit i at [4i+3:4i]); frame_err per digit;
//        sel_err one-cycle pulse after a multi-hot strobe; scan_timeout watchdog status.
// Optional: define SEG7_SCAN_TIMEOUT_EN to enable the scan watchdog (otherwise scan_timeout is held low).
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int STABLE_CNT  = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] frame_bcd,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    sel_err,
    output logic                    scan_timeout
);

    localparam logic [3:0] STABLE = STABLE_CNT[3:0];

    logic [3:0] dec_code;
    logic       dec_err;

    // Single decoder on the shared bus: only the strobed digit's pattern is ever on it.
    seg7_pattern_decode u_decode (
        .seg  (seg),
        .code (dec_code),
        .err  (dec_err)
    );

    logic [3:0] sel_cnt;
    logic       single_hot;
    logic       multi_hot;
    logic       to_fire;

    always_comb begin
        sel_cnt = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_cnt = sel_cnt + {3'b000, digit_sel[i]};
        end
    end

    assign single_hot = (sel_cnt == 4'd1);
    assign multi_hot  = (sel_cnt > 4'd1);

    // Per-digit debounce state and the shadow frame being assembled.
    logic [NUM_DIGITS-1:0][3:0] cand_code,   cand_code_nxt;
    logic [NUM_DIGITS-1:0]      cand_err,    cand_err_nxt;
    logic [NUM_DIGITS-1:0][3:0] count,       count_nxt;
    logic [NUM_DIGITS-1:0][3:0] shadow_code, shadow_code_nxt;
    logic [NUM_DIGITS-1:0]      shadow_err,  shadow_err_nxt;
    logic [NUM_DIGITS-1:0]      committed,   committed_nxt;
    logic [NUM_DIGITS-1:0]      commit_now;
    logic [NUM_DIGITS-1:0][3:0] frame_code,  frame_code_nxt;
    logic [NUM_DIGITS-1:0]      frame_err_q, frame_err_nxt;

    scan_state_t state_q, state_nxt;

    always_comb begin
        cand_code_nxt   = cand_code;
        cand_err_nxt    = cand_err;
        count_nxt       = count;
        shadow_code_nxt = shadow_code;
        shadow_err_nxt  = shadow_err;
        commit_now      = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (single_hot && digit_sel[i]) begin
                if ((cand_code[i] == dec_code) && (cand_err[i] == dec_err)) begin
                    if (count[i] < STABLE) begin
                        count_nxt[i] = count[i] + 4'd1;
                    end
                end else begin
                    cand_code_nxt[i] = dec_code;
                    cand_err_nxt[i]  = dec_err;
                    count_nxt[i]     = 4'd1;
                end
                // A saturated stable digit re-commits on every strobe, so a
                // held display refills committed[] one strobe per digit.
                if (count_nxt[i] == STABLE) begin
                    commit_now[i]      = 1'b1;
                    shadow_code_nxt[i] = dec_code;
                    shadow_err_nxt[i]  = dec_err;
                end
            end
        end
        if (to_fire) begin
            count_nxt = '0;
        end
    end

    // Frame FSM: COLLECT counts current-edge commits toward completion; at a
    // handshake in OFFER only already-registered commits count, so a commit
    // landing on the handshake edge goes to the following frame.
    always_comb begin
        state_nxt      = state_q;
        out_valid      = 1'b0;
        frame_code_nxt = frame_code;
        frame_err_nxt  = frame_err_q;
        committed_nxt  = committed | commit_now;
        case (state_q)
            COLLECT: begin
                if (&(committed | commit_now)) begin
                    frame_code_nxt = shadow_code_nxt;
                    frame_err_nxt  = shadow_err_nxt;
                    committed_nxt  = '0;
                    state_nxt      = OFFER;
                end
            end
            OFFER: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (&committed) begin
                        frame_code_nxt = shadow_code;
                        frame_err_nxt  = shadow_err;
                        committed_nxt  = commit_now;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
        if (to_fire) begin
            committed_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_code   <= '0;
            cand_err    <= '0;
            count       <= '0;
            shadow_code <= '0;
            shadow_err  <= '0;
            committed   <= '0;
            frame_code  <= '0;
            frame_err_q <= '0;
            sel_err     <= 1'b0;
        end else begin
            cand_code   <= cand_code_nxt;
            cand_err    <= cand_err_nxt;
            count       <= count_nxt;
            shadow_code <= shadow_code_nxt;
            shadow_err  <= shadow_err_nxt;
            committed   <= committed_nxt;
            frame_code  <= frame_code_nxt;
            frame_err_q <= frame_err_nxt;
            sel_err     <= multi_hot;
        end
    end

    assign frame_bcd = frame_code;
    assign frame_err = frame_err_q;

`ifdef SEG7_SCAN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);

    logic [TW-1:0] to_cnt;
    logic          to_flag;

    // Fires once, on the TIMEOUT_CYC-th clock without a single-hot strobe;
    // the counter then parks at TIMEOUT_CYC until the next strobe.
    assign to_fire = !single_hot && (to_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else if (single_hot) begin
            to_cnt  <= '0;
            to_flag <= 1'b0;
        end else begin
            if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + TW'(1);
            end
            if (to_fire) begin
                to_flag <= 1'b1;
            end
        end
    end

    assign scan_timeout = to_flag;
`else
    assign to_fire = 1'b0;
    // Watchdog absent: constant low for any legal (positive) TIMEOUT_CYC.
    assign scan_timeout = (TIMEOUT_CYC < 1);
`endif

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the BCD-to-seven-segment encoder.
- Watches a multiplexed seven-segment scan bus: a shared segment vector plus one-hot digit strobes.
- Debounces each digit's pattern and decodes it back to BCD.
- Presents complete multi-digit frames to downstream logic over a valid/ready handshake.
- Used for self-checking display paths and for reading back display drivers.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (1..8).
- STABLE_CNT, 3: consecutive identical strobes of a digit required before its value commits (1..15).
- TIMEOUT_CYC, 1024: watchdog limit in clocks; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- seg  in  7  segment levels, active-high; seg[6]=A (top) … seg[0]=G (middle).
- digit_sel  in  NUM_DIGITS  one-hot digit strobe; bit i = digit i sampled this cycle.
- out_valid  out  1  frame available.
- out_ready  in  1  downstream accepts frame.
- frame_bcd  out  4*NUM_DIGITS  digit i at [4i+3:4i].
- frame_err  out  NUM_DIGITS  digit i pattern was illegal.
- sel_err  out  1  one-cycle pulse: more than one digit_sel bit set.
- scan_timeout  out  1  optional-feature status.

Behaviour:
- Reset (async assert, sync-release assumed upstream) clears all state:
  - out_valid=0, frame_bcd=0, frame_err=0, sel_err=0, scan_timeout=0.
  - Internal per-digit candidate=0, match count=0, committed flags=0, FSM=COLLECT.
- Reset mid-frame discards the partial frame; no out_valid until a full new frame is collected.
- Decode table, pattern ABCDEFG -> code:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5.
  - 6 accepts 1011111 or 0011111.
  - 7 accepts 1110000 or 1110010.
  - 8 accepts 1111111.
  - 9 accepts 1111011 or 1110011.
  - 0000000 -> 4'hF (blank, not an error).
  - Any other pattern -> 4'hE with err=1.
- Sampling:
  - digit_sel==0: idle cycle, no state change.
  - More than one bit set: sample ignored; sel_err pulses high for the next cycle.
  - Exactly one bit i set: compare the decoded {code, err} against candidate[i].
    - Equal: count[i] increments, saturating at STABLE_CNT.
    - Different: candidate[i] takes the new value and count[i]=1.
  - When count[i] reaches STABLE_CNT on this edge, digit i commits: shadow value updates and committed[i]=1.
  - A commit is therefore visible in the cycle after the STABLE_CNT-th matching strobe.
  - STABLE_CNT=1 commits on every strobe.
- FSM COLLECT:
  - out_valid=0.
  - When all committed[] bits are 1 (including commits on the current edge), the next edge copies shadow to frame_bcd/frame_err, clears committed[], sets out_valid=1, and moves to OFFER.
- FSM OFFER:
  - out_valid=1; frame_bcd/frame_err are held stable.
  - Sampling and commits continue into shadow/committed[] for the next frame.
  - On the edge where out_valid & out_ready: return to COLLECT with out_valid=0 the next cycle.
  - If committed[] is already all 1 on that edge, go straight back to OFFER with the fresh shadow, so out_valid stays 1 with the new frame.
- Simultaneous commit and handshake on the same edge: the commit belongs to the next frame.
- A digit that never strobes stalls frame delivery indefinitely (unless the optional feature is enabled).

Optional Feature:
- Macro SEG7_SCAN_TIMEOUT_EN.
- Defined:
  - A counter counts clocks since the last single-hot strobe and resets on each one.
  - At TIMEOUT_CYC it sets scan_timeout=1 (sticky until the next single-hot strobe) and clears committed[] and count[].
  - out_valid is unaffected if the FSM is already in OFFER.
- Undefined: no counter; scan_timeout is tied to 0.

Decomposition:
- Package seg7_pkg holds:
  - The ten primary and three alternate segment pattern constants.
  - BCD_BLANK=4'hF and BCD_ERR=4'hE.
  - The FSM state typedef {COLLECT, OFFER}.
- Sub-module seg7_pattern_decode: purely combinational, 7-bit pattern -> {code[3:0], err}. Instantiate it once, on the shared seg bus.

Test Plan:
- Reset then strobe digits 0..3, three cycles each, with patterns for 1,2,3,4 -> out_valid=1 one cycle after the last commit, frame_bcd=16'h4321, frame_err=0.
- Digit 2 pattern alternates 0110000/1101101 every strobe -> digit 2 never commits and out_valid stays 0. Then hold 1111001 for three strobes -> frame has digit2=3.
- Pattern 1000001 on digit 1 (stable) -> frame_bcd[7:4]=4'hE, frame_err[1]=1. Pattern 0000000 -> 4'hF with err=0.
- digit_sel=4'b0110 -> sel_err pulses one cycle and the match count is unchanged. Also hold out_ready=0 across two full scans -> frame_bcd stays frozen; asserting ready then delivers the second frame the very next cycle.
- Assert rst_n=0 mid-collection, after two digits have committed -> all outputs 0 immediately (async); after release, a full four-digit scan is required before out_valid.
- With SEG7_SCAN_TIMEOUT_EN and TIMEOUT_CYC=16: hold digit_sel=0 for 16 cycles -> scan_timeout=1 and committed cleared; the next strobe clears scan_timeout.
